// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss-handling (line fill) sequencer.
// Included first so the counter and top-level can import it.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVICT   = 2'd1,
    FETCH   = 2'd2,
    INSTALL = 2'd3
  } fillstate_t;

  // Decoded control outputs, kept together so the output decoder has one default.
  typedef struct packed {
    logic bus_read;
    logic bus_write;
    logic fill_we;
    logic clear_valid;
    logic set_valid;
    logic clear_dirty;
    logic lru_we;
    logic stall;
  } fill_ctrl_t;

  localparam fill_ctrl_t FILL_CTRL_NONE = '0;

  // Beat index width; a one-beat line still gets a 1-bit counter port.
  function automatic int beat_len(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/cache_beat_counter.sv
// Beat index counter for line transfers: clear has priority over enable,
// and last flags the final beat of a line.
module cache_beat_counter
  import cache_pkg::*;
#(
  parameter  int BEATS = 8,
  localparam int W     = beat_len(BEATS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] LAST_IDX = W'(BEATS - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    // NOTE: default assignment first, so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for flops, so all registers update together at the edge.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == LAST_IDX);

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// Miss-handling sequencer: latches the victim way, writes it back if dirty,
// fetches the new line beat by beat, then pulses the tag/LRU install updates.
module cache_line_fill_ctrl
  import cache_pkg::*;
#(
  parameter  int NUMWAYS = 4,
  parameter  int LINELEN = 512,
  parameter  int BUSW    = 64,
  localparam int BEATS   = LINELEN / BUSW,
  localparam int BEATLEN = beat_len(BEATS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CacheMiss,
  input  logic               FlushStage,
  input  logic [NUMWAYS-1:0] VictimWay,
  input  logic               VictimDirty,
  input  logic               BusBeatAck,
  output logic               BusRead,
  output logic               BusWrite,
  output logic [BEATLEN-1:0] BeatCount,
  output logic [NUMWAYS-1:0] SelWay,
  output logic               FillWriteEn,
  output logic               ClearValid,
  output logic               SetValid,
  output logic               ClearDirty,
  output logic               LRUWriteEn,
  output logic               CacheStall
);

  fillstate_t         state_q;
  fillstate_t         state_d;
  logic [NUMWAYS-1:0] sel_way_q;
  logic [NUMWAYS-1:0] sel_way_d;

  logic       start;
  logic       on_bus;
  logic       beat_done;
  logic       beat_last;
  fill_ctrl_t ctrl;

  // A miss only starts from IDLE; reset also blocks it so nothing is latched that cycle.
  assign start     = (state_q == IDLE) && CacheMiss && !FlushStage && !reset;
  assign on_bus    = (state_q == EVICT) || (state_q == FETCH);
  assign beat_done = on_bus && BusBeatAck;

  cache_beat_counter #(
    .BEATS (BEATS)
  ) u_beat_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (beat_done && beat_last),
    .enable (beat_done),
    .count  (BeatCount),
    .last   (beat_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = VictimDirty ? EVICT : FETCH;
        end
      end
      EVICT: begin
        if (BusBeatAck && beat_last) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (BusBeatAck && beat_last) begin
          state_d = INSTALL;
        end
      end
      INSTALL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Victim way register, loaded only when a miss is accepted
  assign sel_way_d = start ? VictimWay : sel_way_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_way_q <= '0;
    end else begin
      sel_way_q <= sel_way_d;
    end
  end

  // Output decode; held quiet while reset is asserted so reset wins mid-transfer too.
  always_comb begin
    ctrl = FILL_CTRL_NONE;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          ctrl.clear_valid = start;
          ctrl.stall       = start;
        end
        EVICT: begin
          ctrl.bus_write = 1'b1;
          ctrl.stall     = 1'b1;
        end
        FETCH: begin
          ctrl.bus_read = 1'b1;
          ctrl.fill_we  = BusBeatAck;
          ctrl.stall    = 1'b1;
        end
        INSTALL: begin
          ctrl.set_valid   = 1'b1;
          ctrl.clear_dirty = 1'b1;
          ctrl.lru_we      = 1'b1;
          ctrl.stall       = 1'b1;
        end
        default: ctrl = FILL_CTRL_NONE;
      endcase
    end
  end

  assign BusRead     = ctrl.bus_read;
  assign BusWrite    = ctrl.bus_write;
  assign FillWriteEn = ctrl.fill_we;
  assign ClearValid  = ctrl.clear_valid;
  assign SetValid    = ctrl.set_valid;
  assign ClearDirty  = ctrl.clear_dirty;
  assign LRUWriteEn  = ctrl.lru_we;
  assign CacheStall  = ctrl.stall;
  assign SelWay      = sel_way_q;

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Self-checking bench for cache_line_fill_ctrl: an 8-beat instance and a
// single-beat (BUSW=512) instance, checked against an expected-event scoreboard.
module tb_cache_line_fill_ctrl;

  localparam logic [2:0] EV_START = 3'd1;
  localparam logic [2:0] EV_WR    = 3'd2;
  localparam logic [2:0] EV_RD    = 3'd3;
  localparam logic [2:0] EV_INST  = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic [3:0] way;
    logic [3:0] beat;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] last_way = 4'b0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-beat DUT
  logic       reset, CacheMiss, FlushStage, VictimDirty, BusBeatAck;
  logic [3:0] VictimWay;
  logic       BusRead, BusWrite, FillWriteEn, ClearValid, SetValid, ClearDirty, LRUWriteEn, CacheStall;
  logic [2:0] BeatCount;
  logic [3:0] SelWay;

  // single-beat DUT
  logic       s_reset, s_CacheMiss, s_FlushStage, s_VictimDirty, s_BusBeatAck;
  logic [3:0] s_VictimWay;
  logic       s_BusRead, s_BusWrite, s_FillWriteEn, s_ClearValid, s_SetValid, s_ClearDirty, s_LRUWriteEn, s_CacheStall;
  logic [0:0] s_BeatCount;
  logic [3:0] s_SelWay;

  cache_line_fill_ctrl #(.NUMWAYS(4), .LINELEN(512), .BUSW(64)) dut (
    .clk(clk), .reset(reset), .CacheMiss(CacheMiss), .FlushStage(FlushStage),
    .VictimWay(VictimWay), .VictimDirty(VictimDirty), .BusBeatAck(BusBeatAck),
    .BusRead(BusRead), .BusWrite(BusWrite), .BeatCount(BeatCount), .SelWay(SelWay),
    .FillWriteEn(FillWriteEn), .ClearValid(ClearValid), .SetValid(SetValid),
    .ClearDirty(ClearDirty), .LRUWriteEn(LRUWriteEn), .CacheStall(CacheStall)
  );

  cache_line_fill_ctrl #(.NUMWAYS(4), .LINELEN(512), .BUSW(512)) dut_single (
    .clk(clk), .reset(s_reset), .CacheMiss(s_CacheMiss), .FlushStage(s_FlushStage),
    .VictimWay(s_VictimWay), .VictimDirty(s_VictimDirty), .BusBeatAck(s_BusBeatAck),
    .BusRead(s_BusRead), .BusWrite(s_BusWrite), .BeatCount(s_BeatCount), .SelWay(s_SelWay),
    .FillWriteEn(s_FillWriteEn), .ClearValid(s_ClearValid), .SetValid(s_SetValid),
    .ClearDirty(s_ClearDirty), .LRUWriteEn(s_LRUWriteEn), .CacheStall(s_CacheStall)
  );

  function automatic logic [7:0] outs();
    return {BusRead, BusWrite, FillWriteEn, ClearValid, SetValid, ClearDirty, LRUWriteEn, CacheStall};
  endfunction

  function automatic logic [7:0] s_outs();
    return {s_BusRead, s_BusWrite, s_FillWriteEn, s_ClearValid, s_SetValid, s_ClearDirty, s_LRUWriteEn, s_CacheStall};
  endfunction

  // Drives one miss on the 8-beat DUT, pushes the expected event stream and
  // records what the DUT produces. Entered and left just after a rising edge.
  task automatic drive_miss(input logic [3:0] way, input logic dirty, input int max_gap,
                            input logic flush_mid, output int stall_cycles, output int fill_cnt,
                            output int overlap_cnt, output int hold_viol, output bit timed_out);
    int gap_left;
    bit done;
    logic busy, prev_busy, prev_ack;
    logic [2:0] prev_cnt;
    stall_cycles = 0; fill_cnt = 0; overlap_cnt = 0; hold_viol = 0;
    exp_q.push_back({EV_START, 4'b0000, 4'd1});
    if (dirty) for (int b = 0; b < 8; b++) exp_q.push_back({EV_WR, way, 4'(b)});
    for (int b = 0; b < 8; b++) exp_q.push_back({EV_RD, way, 4'(b)});
    exp_q.push_back({EV_INST, way, 4'd3});
    CacheMiss = 1'b1; VictimWay = way; VictimDirty = dirty; FlushStage = 1'b0; BusBeatAck = 1'b0;
    gap_left = 0; done = 0; prev_busy = 0; prev_ack = 0; prev_cnt = '0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      if (ClearValid) obs_q.push_back({EV_START, 4'b0000, 4'(CacheStall)});
      if (BusWrite && BusBeatAck) obs_q.push_back({EV_WR, SelWay, 4'(BeatCount)});
      if (FillWriteEn) obs_q.push_back({EV_RD, BusRead ? SelWay : 4'b0000, 4'(BeatCount)});
      if (SetValid) obs_q.push_back({EV_INST, SelWay, {2'b00, ClearDirty, LRUWriteEn}});
      if (BusRead && BusWrite) overlap_cnt++;
      if (CacheStall) stall_cycles++;
      if (FillWriteEn) fill_cnt++;
      busy = BusRead | BusWrite;
      if (prev_busy && !prev_ack && busy && BeatCount !== prev_cnt) hold_viol++;
      prev_busy = busy; prev_ack = BusBeatAck; prev_cnt = BeatCount;
      if (SetValid) done = 1;
      @(posedge clk); #1;
      CacheMiss = 1'b0;
      if (done) begin
        BusBeatAck = 1'b0; FlushStage = 1'b0;
      end else begin
        FlushStage = flush_mid;
        if (gap_left > 0) begin
          BusBeatAck = 1'b0; gap_left--;
        end else begin
          BusBeatAck = 1'b1; gap_left = $urandom_range(max_gap, 0);
        end
      end
    end
    timed_out = !done;
    last_way = way;
  endtask

  task automatic test_reset;
    reset = 1'b1; CacheMiss = 1'b1; FlushStage = 1'b0; VictimWay = 4'b1111; VictimDirty = 1'b1; BusBeatAck = 1'b1;
    s_reset = 1'b1; s_CacheMiss = 1'b1; s_FlushStage = 1'b0; s_VictimWay = 4'b1111; s_VictimDirty = 1'b1; s_BusBeatAck = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (outs() !== 8'h00) begin n_err++; $display("FAIL reset_outs: got %b expected %b", outs(), 8'h00); end
    n_vec++; if (SelWay !== 4'b0000 || BeatCount !== 3'd0) begin n_err++; $display("FAIL reset_regs: got way %b cnt %0d expected way 0000 cnt 0", SelWay, BeatCount); end
    n_vec++; if (s_outs() !== 8'h00 || s_SelWay !== 4'b0000 || s_BeatCount !== 1'b0) begin n_err++; $display("FAIL reset_single: got outs %b way %b expected 0", s_outs(), s_SelWay); end
    @(posedge clk); #1;
    reset = 1'b0; CacheMiss = 1'b0; BusBeatAck = 1'b0; VictimDirty = 1'b0;
    s_reset = 1'b0; s_CacheMiss = 1'b0; s_BusBeatAck = 1'b0; s_VictimDirty = 1'b0;
    @(negedge clk);
    n_vec++; if (outs() !== 8'h00) begin n_err++; $display("FAIL idle_after_reset: got %b expected %b", outs(), 8'h00); end
    @(posedge clk); #1;
  endtask

  task automatic test_miss(input string name, input logic [3:0] way, input logic dirty,
                           input int max_gap, input logic flush_mid, input int exp_stall);
    int stall, fills, overlap, hold;
    bit tmo;
    ev_t e, o;
    drive_miss(way, dirty, max_gap, flush_mid, stall, fills, overlap, hold, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL %s_timeout: got no install, expected install", name); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL %s_event_count: got %0d expected %0d", name, obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL %s_missing_event: got none expected %h", name, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL %s_event: got kind %0d way %b beat %0d expected kind %0d way %b beat %0d", name, o.kind, o.way, o.beat, e.kind, e.way, e.beat); end
      end
    end
    obs_q.delete();
    n_vec++; if (fills != 8) begin n_err++; $display("FAIL %s_fill_count: got %0d expected 8", name, fills); end
    n_vec++; if (overlap != 0) begin n_err++; $display("FAIL %s_rd_wr_overlap: got %0d expected 0", name, overlap); end
    n_vec++; if (hold != 0) begin n_err++; $display("FAIL %s_beat_hold: got %0d changes expected 0", name, hold); end
    if (exp_stall > 0) begin
      n_vec++; if (stall != exp_stall) begin n_err++; $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stall, exp_stall); end
    end
    @(negedge clk);
    n_vec++; if (CacheStall !== 1'b0 || SetValid !== 1'b0) begin n_err++; $display("FAIL %s_after_install: got stall %b setvalid %b expected 0 0", name, CacheStall, SetValid); end
    @(posedge clk); #1;
  endtask

  task automatic test_clean_miss;
    test_miss("clean", 4'b0100, 1'b0, 0, 1'b0, 10);
  endtask

  task automatic test_dirty_miss;
    test_miss("dirty", 4'b0001, 1'b1, 0, 1'b0, 18);
  endtask

  task automatic test_flush_fetch;
    test_miss("flush_fetch", 4'b0010, 1'b0, 0, 1'b1, 10);
  endtask

  task automatic test_random_gaps;
    test_miss("gaps", 4'b1000, 1'b1, 5, 1'b0, 0);
  endtask

  task automatic test_flush_idle;
    CacheMiss = 1'b1; FlushStage = 1'b1; VictimWay = 4'b1111; VictimDirty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (ClearValid !== 1'b0 || CacheStall !== 1'b0) begin n_err++; $display("FAIL flush_idle_pulse: got clrv %b stall %b expected 0 0", ClearValid, CacheStall); end
      @(posedge clk); #1;
    end
    CacheMiss = 1'b0; FlushStage = 1'b0; VictimDirty = 1'b0;
    @(negedge clk);
    n_vec++; if (SelWay !== last_way || outs() !== 8'h00) begin n_err++; $display("FAIL flush_idle_state: got way %b outs %b expected way %b outs 0", SelWay, outs(), last_way); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fetch;
    CacheMiss = 1'b1; VictimWay = 4'b1000; VictimDirty = 1'b0; BusBeatAck = 1'b0;
    @(posedge clk); #1;
    CacheMiss = 1'b0; BusBeatAck = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    BusBeatAck = 1'b0;
    @(negedge clk);
    n_vec++; if (BeatCount !== 3'd3 || BusRead !== 1'b1) begin n_err++; $display("FAIL mid_fetch_beat: got cnt %0d rd %b expected 3 1", BeatCount, BusRead); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (BeatCount !== 3'd0 || BusRead !== 1'b0 || SelWay !== 4'b0000 || CacheStall !== 1'b0) begin
      n_err++; $display("FAIL mid_fetch_reset: got cnt %0d rd %b way %b stall %b expected 0 0 0000 0", BeatCount, BusRead, SelWay, CacheStall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat;
    s_CacheMiss = 1'b1; s_VictimWay = 4'b0010; s_VictimDirty = 1'b0; s_BusBeatAck = 1'b0;
    @(negedge clk);
    n_vec++; if (s_ClearValid !== 1'b1 || s_CacheStall !== 1'b1) begin n_err++; $display("FAIL single_start: got clrv %b stall %b expected 1 1", s_ClearValid, s_CacheStall); end
    @(posedge clk); #1;
    s_CacheMiss = 1'b0; s_BusBeatAck = 1'b1;
    @(negedge clk);
    n_vec++; if (s_BusRead !== 1'b1 || s_FillWriteEn !== 1'b1 || s_BeatCount !== 1'b0) begin n_err++; $display("FAIL single_fetch: got rd %b fwe %b cnt %0d expected 1 1 0", s_BusRead, s_FillWriteEn, s_BeatCount); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (s_SetValid !== 1'b1 || s_BusRead !== 1'b0 || s_BeatCount !== 1'b0 || s_SelWay !== 4'b0010) begin
      n_err++; $display("FAIL single_install: got setv %b rd %b cnt %0d way %b expected 1 0 0 0010", s_SetValid, s_BusRead, s_BeatCount, s_SelWay);
    end
    @(posedge clk); #1;
    s_BusBeatAck = 1'b0;
    @(negedge clk);
    n_vec++; if (s_CacheStall !== 1'b0 || s_SetValid !== 1'b0) begin n_err++; $display("FAIL single_done: got stall %b setv %b expected 0 0", s_CacheStall, s_SetValid); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_flush_idle();
    test_flush_fetch();
    test_random_gaps();
    test_reset_mid_fetch();
    test_single_beat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
